axi_rd_arbiter: RTL

Two-requester arbiter for the shared AXI read address and read data channels (AR/R) between the instruction cache and the data cache inside the AXI MMU. It replaces OR-ing the requesters' AR signals onto the bus: exactly one requester owns AR/R from address issue until the final R beat. The instruction requester has fixed priority, with a starvation guard for the data requester. The block also checks each burst's beat count.

---
 rtl/axi_rd_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-requester AR/R read channel arbiter with starvation guard and burst length check
//
// Arbitrates the shared AXI read address/data channels between the
// instruction cache (fixed priority) and the data cache. One requester owns
// AR/R from grant until its final R beat. The data requester is granted after
// STARVE_LIMIT consecutive instruction grants made while it was waiting.
// Each burst's beat count is checked against its ARLEN; any mismatch raises
// a sticky LEN_ERR.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   S_INST_AR{ADDR,LEN,VALID} instruction read request
//   S_INST_ARREADY           instruction request accepted (1-cycle pulse)
//   S_INST_R{VALID,LAST}     R beat valid / last, gated to instruction owner
//   S_DATA_AR{ADDR,LEN,VALID} data read request
//   S_DATA_ARREADY           data request accepted (1-cycle pulse)
//   S_DATA_R{VALID,LAST}     R beat valid / last, gated to data owner
//   M_AXI_AR*                registered read address channel to the bus
//   M_AXI_R{VALID,LAST}      R channel handshake from the bus
//   M_AXI_RREADY             R ready, high only while a burst is outstanding
//   LEN_ERR                  sticky burst-length mismatch flag
// RDATA/RRESP go straight from the bus to both requesters.

module axi_rd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [2:0]  AR_SIZE      = 3'b010,
    parameter logic [1:0]  AR_BURST     = 2'b01
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic [31:0] S_INST_ARADDR,
    input  logic [7:0]  S_INST_ARLEN,
    input  logic        S_INST_ARVALID,
    output logic        S_INST_ARREADY,
    output logic        S_INST_RVALID,
    output logic        S_INST_RLAST,

    input  logic [31:0] S_DATA_ARADDR,
    input  logic [7:0]  S_DATA_ARLEN,
    input  logic        S_DATA_ARVALID,
    output logic        S_DATA_ARREADY,
    output logic        S_DATA_RVALID,
    output logic        S_DATA_RLAST,

    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic        M_AXI_RVALID,
    input  logic        M_AXI_RLAST,
    output logic        M_AXI_RREADY,

    output logic        LEN_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [8:0]  beat_q, beat_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        len_err_q, len_err_d;

    logic        grant_inst;
    logic        grant_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= OWN_INST;
            starve_q  <= 4'd0;
            beat_q    <= 9'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            beat_q    <= beat_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_d       = starve_q;
        beat_d         = beat_q;
        araddr_d       = araddr_q;
        arlen_d        = arlen_q;
        len_err_d      = len_err_q;
        grant_inst     = 1'b0;
        grant_data     = 1'b0;
        S_INST_ARREADY = 1'b0;
        S_DATA_ARREADY = 1'b0;
        S_INST_RVALID  = 1'b0;
        S_INST_RLAST   = 1'b0;
        S_DATA_RVALID  = 1'b0;
        S_DATA_RLAST   = 1'b0;
        M_AXI_ARVALID  = 1'b0;
        M_AXI_RREADY   = 1'b0;

        case (state_q)
            IDLE: begin
                // Starvation guard overrides the fixed instruction priority.
                if (starve_q == STARVE_MAX && S_DATA_ARVALID) begin
                    grant_data = 1'b1;
                end else if (S_INST_ARVALID) begin
                    grant_inst = 1'b1;
                end else if (S_DATA_ARVALID) begin
                    grant_data = 1'b1;
                end

                if (grant_inst) begin
                    S_INST_ARREADY = 1'b1;
                    araddr_d       = S_INST_ARADDR;
                    arlen_d        = S_INST_ARLEN;
                    owner_d        = OWN_INST;
                    beat_d         = 9'd0;
                    state_d        = ADDR;
                    // Only grants that made the data side wait count toward starvation.
                    if (S_DATA_ARVALID && starve_q < STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (grant_data) begin
                    S_DATA_ARREADY = 1'b1;
                    araddr_d       = S_DATA_ARADDR;
                    arlen_d        = S_DATA_ARLEN;
                    owner_d        = OWN_DATA;
                    beat_d         = 9'd0;
                    state_d        = ADDR;
                    starve_d       = 4'd0;
                end
            end

            ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                M_AXI_RREADY = 1'b1;
                if (owner_q == OWN_INST) begin
                    S_INST_RVALID = M_AXI_RVALID;
                    S_INST_RLAST  = M_AXI_RVALID & M_AXI_RLAST;
                end else begin
                    S_DATA_RVALID = M_AXI_RVALID;
                    S_DATA_RLAST  = M_AXI_RVALID & M_AXI_RLAST;
                end

                if (M_AXI_RVALID) begin
                    beat_d = beat_q + 9'd1;
                    if (M_AXI_RLAST) begin
                        // beat_q counts the beats before this one, so a
                        // correct burst ends with beat_q == ARLEN.
                        if (beat_q != {1'b0, arlen_q}) begin
                            len_err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (beat_q >= {1'b0, arlen_q}) begin
                        // More than ARLEN+1 beats without RLAST: flag it,
                        // but keep the channel owned until the slave ends it.
                        len_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = AR_SIZE;
    assign M_AXI_ARBURST = AR_BURST;
    assign LEN_ERR       = len_err_q;

endmodule
